td4_core: RTL

- Fetch/execute engine for the 4-bit TD4 CPU. It is the reader side of the 16x8 program ROM: it drives the ROM address and consumes the returned instruction byte.
- Holds registers A and B, the carry flag, the PC and the output latch. Executes one instruction per enabled clock.
- Sits between the program ROM and the board I/O: switches on IN_PORT, LEDs on OUT_PORT.

---
 rtl/td4_pkg.sv | 20 ++
 rtl/td4_if.sv | 8 +
 rtl/td4_alu.sv | 18 +
 rtl/td4_core.sv | 60 ++++++
 4 files changed

// File: rtl/td4_pkg.sv
// td4_pkg: shared widths, opcodes, reset defaults and ALU source select for the TD4 core
package td4_pkg;
  localparam int TD4_DW = 4;
  localparam int TD4_IW = 8;
  localparam logic [TD4_DW-1:0] RESET_PC_DEF = 4'h0;
  localparam logic [TD4_DW-1:0] RESET_OUT_DEF = 4'h0;
  localparam logic [3:0] OP_ADD_A = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A = 4'b0010;
  localparam logic [3:0] OP_MOV_AI = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B = 4'b0101;
  localparam logic [3:0] OP_IN_B = 4'b0110;
  localparam logic [3:0] OP_MOV_BI = 4'b0111;
  localparam logic [3:0] OP_OUT_B = 4'b1001;
  localparam logic [3:0] OP_OUT_IM = 4'b1011;
  localparam logic [3:0] OP_JNC = 4'b1110;
  localparam logic [3:0] OP_JMP = 4'b1111;
  typedef enum logic [1:0] {SRC_A, SRC_B, SRC_IN, SRC_ZERO} src_e;
endpackage

// File: rtl/td4_if.sv
// td4_if: program ROM bus (master = core drives ROM_ADDR, slave = ROM returns ROM_DATA combinationally)
interface td4_if;
  import td4_pkg::*;
  logic [TD4_DW-1:0] ROM_ADDR;
  logic [TD4_IW-1:0] ROM_DATA;
  modport master(output ROM_ADDR, input ROM_DATA);
  modport slave(input ROM_ADDR, output ROM_DATA);
endinterface

// File: rtl/td4_alu.sv
// td4_alu: source mux (A/B/IN/zero) plus 4-bit adder with carry-out; sel, a, b, in_port, im in; y, co out
module td4_alu
  import td4_pkg::*;
(
  input  src_e              sel,
  input  logic [TD4_DW-1:0] a,
  input  logic [TD4_DW-1:0] b,
  input  logic [TD4_DW-1:0] in_port,
  input  logic [TD4_DW-1:0] im,
  output logic [TD4_DW-1:0] y,
  output logic              co
);
  logic [TD4_DW-1:0] opnd;
  always_comb begin
    opnd = sel == SRC_A ? a : sel == SRC_B ? b : sel == SRC_IN ? in_port : '0;
    {co, y} = {1'b0, opnd} + {1'b0, im};
  end
endmodule

// File: rtl/td4_core.sv
// td4_core: TD4 fetch/execute engine; CLK, CLR_N (async low), EN step, rom bus, IN_PORT in; OUT_PORT, DBG_A/B/C out
module td4_core
  import td4_pkg::*;
#(
  parameter logic [TD4_DW-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [TD4_DW-1:0] RESET_OUT = RESET_OUT_DEF
) (
  input  logic              CLK,
  input  logic              CLR_N,
  input  logic              EN,
  td4_if.master             rom,
  input  logic [TD4_DW-1:0] IN_PORT,
  output logic [TD4_DW-1:0] OUT_PORT,
  output logic [TD4_DW-1:0] DBG_A,
  output logic [TD4_DW-1:0] DBG_B,
  output logic              DBG_C
);
  logic [TD4_DW-1:0] a, b, pc, im, y;
  logic [3:0] op;
  logic c, co, ld_a, ld_b, ld_o, is_add, use_im, jmp;
  src_e sel;
  assign op = rom.ROM_DATA[7:4];
  assign im = rom.ROM_DATA[3:0];
  assign rom.ROM_ADDR = pc;
  assign DBG_A = a;
  assign DBG_B = b;
  assign DBG_C = c;
  // opcode low bits map directly onto the source select for every data-moving instruction
  assign sel = src_e'(op[1:0]);
  assign ld_a = op inside {OP_ADD_A, OP_MOV_AB, OP_IN_A, OP_MOV_AI};
  assign ld_b = op inside {OP_MOV_BA, OP_ADD_B, OP_IN_B, OP_MOV_BI};
  assign ld_o = op inside {OP_OUT_B, OP_OUT_IM};
  assign is_add = op inside {OP_ADD_A, OP_ADD_B};
  assign use_im = op inside {OP_ADD_A, OP_ADD_B, OP_MOV_AI, OP_MOV_BI, OP_OUT_IM};
  assign jmp = op == OP_JMP || (op == OP_JNC && !c);
  td4_alu u_alu (
    .sel(sel),
    .a(a),
    .b(b),
    .in_port(IN_PORT),
    .im(use_im ? im : '0),
    .y(y),
    .co(co)
  );
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      pc <= RESET_PC;
      a <= '0;
      b <= '0;
      c <= 1'b0;
      OUT_PORT <= RESET_OUT;
    end else if (EN) begin
      a <= ld_a ? y : a;
      b <= ld_b ? y : b;
      OUT_PORT <= ld_o ? y : OUT_PORT;
      c <= is_add & co;
      pc <= jmp ? im : pc + 4'd1;
    end
  end
endmodule
